// File: rtl/c64_sd_pkg.sv
// Shared definitions for the SD image loader/saver: slot indices, sector geometry,
// save FSM states and the slot-to-write-request helper.
package c64_sd_pkg;

  localparam int unsigned SLOT_C1541 = 0;
  localparam int unsigned SLOT_CRT   = 1;
  localparam int unsigned SLOT_PRG   = 2;
  localparam int unsigned SLOT_BIN   = 3;
  localparam int unsigned SLOT_TAP   = 4;
  localparam int unsigned SLOT_FLT   = 5;
  localparam int unsigned NUM_SLOTS  = 6;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_AW    = $clog2(SECTOR_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FILL,
    ST_FILL_WAIT,
    ST_PAD,
    ST_SD_REQ,
    ST_SD_WAIT,
    ST_FINISH
  } save_state_t;

  // Slot 0 (c1541) has no write request line; slot n drives request bit n-1.
  function automatic logic [NUM_SLOTS-2:0] slot_wr_req(input logic [2:0] sel);
    logic [NUM_SLOTS-2:0] req;
    req = '0;
    for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
      req[i] = (sel == 3'(i + 1));
    end
    return req;
  endfunction

endpackage

// File: rtl/sd_sector_buffer.sv
// One-sector staging RAM: written by the save FSM, read by the SD controller
// through a registered port (one cycle from rd_addr to rd_data).
module sd_sector_buffer
  import c64_sd_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [SECTOR_AW-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic [SECTOR_AW-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [SECTOR_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/saver_sd_card.sv
// Uploads a byte range from the core over ioctl, packs it into zero-padded
// 512-byte sectors and writes them to the selected mounted SD image slot.
module saver_sd_card
  import c64_sd_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned SD_TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        save_req,
  input  logic [2:0]  save_sel,
  input  logic [22:0] save_size,
  output logic        save_busy,
  output logic        save_done,
  output logic        save_err,
  input  logic [5:0]  sd_img_mounted,
  input  logic [31:0] sd_img_size,
  output logic [31:0] sd_lba,
  output logic [4:0]  sd_wr,
  input  logic        sd_busy,
  input  logic        sd_done,
  input  logic [8:0]  sd_byte_index,
  output logic [7:0]  sd_wr_data,
  output logic        ioctl_upload,
  output logic [22:0] ioctl_addr,
  output logic        ioctl_rd,
  input  logic [7:0]  ioctl_din,
  input  logic        ioctl_wait
);

  save_state_t          state, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [22:0]          size_q, size_d;
  logic [22:0]          addr, addr_d, addr_inc;
  logic [SECTOR_AW-1:0] idx, idx_d, idx_inc;
  logic [2:0]           lat_cnt, lat_d;
  logic [31:0]          tmo, tmo_d;
  logic                 busy_d, done_d, err_d, upload_d, rd_d;
  logic [22:0]          ioctl_addr_d;
  logic [31:0]          lba_d;
  logic [4:0]           sd_wr_d;
  logic                 buf_we;
  logic [7:0]           buf_wdata;
  logic                 start_sd, abort;

  logic [22:0]          slot_size [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_present;
  logic                 sel_ok, check_pass;
  logic [2:0]           sel_idx;

  assign addr_inc   = addr + 23'd1;
  assign idx_inc    = idx + 1'b1;
  assign sel_ok     = (sel_q != 3'(SLOT_C1541)) && (sel_q <= 3'(SLOT_FLT));
  assign sel_idx    = sel_ok ? sel_q : '0;
  assign check_pass = sel_ok && slot_present[sel_idx] && (size_q != '0) &&
                      (size_q <= slot_size[sel_idx]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_size[i] <= '0;
      end
      slot_present <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (sd_img_mounted[i]) begin
          slot_size[i]    <= sd_img_size[22:0];
          slot_present[i] <= |sd_img_size;
        end
      end
    end
  end

  sd_sector_buffer u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (buf_we),
    .wr_addr (idx),
    .wr_data (buf_wdata),
    .rd_addr (sd_byte_index),
    .rd_data (sd_wr_data)
  );

  always_comb begin
    state_d      = state;
    sel_d        = sel_q;
    size_d       = size_q;
    addr_d       = addr;
    idx_d        = idx;
    lat_d        = lat_cnt;
    tmo_d        = tmo;
    busy_d       = save_busy;
    done_d       = 1'b0;
    err_d        = 1'b0;
    upload_d     = ioctl_upload;
    rd_d         = 1'b0;
    ioctl_addr_d = ioctl_addr;
    lba_d        = sd_lba;
    sd_wr_d      = sd_wr;
    buf_we       = 1'b0;
    buf_wdata    = ioctl_din;
    start_sd     = 1'b0;
    abort        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (save_req) begin
          sel_d   = save_sel;
          size_d  = save_size;
          busy_d  = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!check_pass) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          addr_d   = '0;
          idx_d    = '0;
          lba_d    = '0;
          upload_d = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!ioctl_wait) begin
          rd_d         = 1'b1;
          ioctl_addr_d = addr;
          lat_d        = '0;
          state_d      = ST_FILL_WAIT;
        end
      end
      ST_FILL_WAIT: begin
        if (lat_cnt == 3'(RD_LATENCY)) begin
          buf_we = 1'b1;
          addr_d = addr_inc;
          idx_d  = idx_inc;
          if (addr_inc == size_q) begin
            if (idx_inc != '0) begin
              state_d = ST_PAD;
            end else begin
              start_sd = 1'b1;
            end
          end else if (idx_inc == '0) begin
            start_sd = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          lat_d = lat_cnt + 3'd1;
        end
      end
      ST_PAD: begin
        buf_we    = 1'b1;
        buf_wdata = 8'h00;
        idx_d     = idx_inc;
        if (idx_inc == '0) begin
          start_sd = 1'b1;
        end
      end
      ST_SD_REQ: begin
        // A same-cycle sd_done is deliberately ignored; only SD_WAIT looks at it.
        if (sd_busy) begin
          sd_wr_d = '0;
          state_d = ST_SD_WAIT;
        end else if (tmo == '0) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo - 32'd1;
        end
      end
      ST_SD_WAIT: begin
        if (sd_done) begin
          if (addr == size_q) begin
            state_d = ST_FINISH;
          end else begin
            lba_d   = sd_lba + 32'd1;
            state_d = ST_FILL;
          end
        end else if (tmo == '0) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo - 32'd1;
        end
      end
      ST_FINISH: begin
        upload_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase

    if (start_sd) begin
      sd_wr_d = slot_wr_req(sel_q);
      tmo_d   = 32'(SD_TIMEOUT);
      state_d = ST_SD_REQ;
    end
    if (abort) begin
      err_d    = 1'b1;
      busy_d   = 1'b0;
      upload_d = 1'b0;
      sd_wr_d  = '0;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      sel_q        <= '0;
      size_q       <= '0;
      addr         <= '0;
      idx          <= '0;
      lat_cnt      <= '0;
      tmo          <= '0;
      save_busy    <= 1'b0;
      save_done    <= 1'b0;
      save_err     <= 1'b0;
      ioctl_upload <= 1'b0;
      ioctl_rd     <= 1'b0;
      ioctl_addr   <= '0;
      sd_lba       <= '0;
      sd_wr        <= '0;
    end else begin
      state        <= state_d;
      sel_q        <= sel_d;
      size_q       <= size_d;
      addr         <= addr_d;
      idx          <= idx_d;
      lat_cnt      <= lat_d;
      tmo          <= tmo_d;
      save_busy    <= busy_d;
      save_done    <= done_d;
      save_err     <= err_d;
      ioctl_upload <= upload_d;
      ioctl_rd     <= rd_d;
      ioctl_addr   <= ioctl_addr_d;
      sd_lba       <= lba_d;
      sd_wr        <= sd_wr_d;
    end
  end

endmodule

// File: tb/tb_saver_sd_card.sv
// Bench for saver_sd_card: table of save requests against a core read model
// and an SD controller model that captures every written sector.
module tb_saver_sd_card;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned TMO    = 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        save_req;
  logic [2:0]  save_sel;
  logic [22:0] save_size;
  logic        save_busy, save_done, save_err;
  logic [5:0]  sd_img_mounted;
  logic [31:0] sd_img_size;
  logic [31:0] sd_lba;
  logic [4:0]  sd_wr;
  logic        sd_busy, sd_done;
  logic [8:0]  sd_byte_index;
  logic [7:0]  sd_wr_data;
  logic        ioctl_upload;
  logic [22:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  always #5 clk = ~clk;

  saver_sd_card #(.RD_LATENCY(RD_LAT), .SD_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .save_req       (save_req),
    .save_sel       (save_sel),
    .save_size      (save_size),
    .save_busy      (save_busy),
    .save_done      (save_done),
    .save_err       (save_err),
    .sd_img_mounted (sd_img_mounted),
    .sd_img_size    (sd_img_size),
    .sd_lba         (sd_lba),
    .sd_wr          (sd_wr),
    .sd_busy        (sd_busy),
    .sd_done        (sd_done),
    .sd_byte_index  (sd_byte_index),
    .sd_wr_data     (sd_wr_data),
    .ioctl_upload   (ioctl_upload),
    .ioctl_addr     (ioctl_addr),
    .ioctl_rd       (ioctl_rd),
    .ioctl_din      (ioctl_din),
    .ioctl_wait     (ioctl_wait)
  );

  function automatic logic [7:0] pat(input logic [22:0] a);
    return (a[7:0] ^ 8'h5A) + (a[15:8] * 8'd37);
  endfunction

  // Core read model: two-stage pipeline matching RD_LAT, garbage when idle.
  logic        rv1 = 1'b0, rv2 = 1'b0;
  logic [22:0] ra1 = '0, ra2 = '0;
  always @(posedge clk) begin
    rv1 <= ioctl_rd;
    ra1 <= ioctl_addr;
    rv2 <= rv1;
    ra2 <= ra1;
  end
  assign ioctl_din = rv2 ? pat(ra2) : 8'hEE;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned rd_cnt, exp_rd_addr, rd_addr_err, rd_in_wait;
  int unsigned done_cnt, err_cnt, sec_cnt, lba_err;
  logic [4:0]  last_wr;
  logic        wait_q = 1'b0;
  bit          sd_en;
  int unsigned sd_cur_lba;
  logic [7:0]  img [0:4095];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) wait_q <= ioctl_wait;

  always @(negedge clk) begin
    if (ioctl_rd) begin
      if (wait_q) rd_in_wait++;
      if (ioctl_addr != 23'(exp_rd_addr)) rd_addr_err++;
      exp_rd_addr++;
      rd_cnt++;
    end
    if (save_done) done_cnt++;
    if (save_err) err_cnt++;
  end

  // SD controller model: accept, stream 512 bytes via sd_byte_index, pulse done.
  initial begin
    sd_busy = 1'b0;
    sd_done = 1'b0;
    sd_byte_index = '0;
    forever begin
      @(negedge clk);
      if (sd_en && reset_n && sd_wr != '0) begin
        sd_cur_lba = sd_lba;
        if (sd_cur_lba != sec_cnt) lba_err++;
        last_wr = sd_wr;
        sec_cnt++;
        @(negedge clk);
        sd_busy = 1'b1;
        for (int i = 0; i <= 512; i++) begin
          @(negedge clk);
          if (!reset_n) break;
          if (i > 0 && sd_cur_lba < 8) img[sd_cur_lba * 512 + i - 1] = sd_wr_data;
          if (i < 512) sd_byte_index = 9'(i);
        end
        if (reset_n) begin
          sd_done = 1'b1;
          @(negedge clk);
          sd_done = 1'b0;
        end
        sd_busy = 1'b0;
      end
    end
  end

  typedef struct {
    logic [2:0]  sel;
    logic [22:0] size;
    int unsigned wait_at;
    logic        exp_err;
    int unsigned exp_sec;
    logic [4:0]  exp_wr;
  } vec_t;

  vec_t vecs [12];

  task automatic clear_counts();
    rd_cnt = 0; exp_rd_addr = 0; rd_addr_err = 0; rd_in_wait = 0;
    done_cnt = 0; err_cnt = 0; sec_cnt = 0; lba_err = 0; last_wr = '0;
    for (int i = 0; i < 4096; i++) img[i] = 8'hCC;
  endtask

  task automatic mount(input int unsigned slot, input logic [31:0] sz);
    @(negedge clk);
    sd_img_mounted = 6'(1 << slot);
    sd_img_size    = sz;
    @(negedge clk);
    sd_img_mounted = '0;
    sd_img_size    = '0;
  endtask

  task automatic run_vec(input int tag, input vec_t v);
    int unsigned cyc, hold, bad;
    bit          wait_done, got_done, got_err;
    logic [7:0]  exp_b;
    clear_counts();
    hold = 0;
    wait_done = 1'b0;
    @(negedge clk);
    save_sel = v.sel; save_size = v.size; save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
    cyc = 1;
    check($sformatf("v%0d_busy_after_req", tag), save_busy, 1);
    while (!save_done && !save_err && cyc < 40000) begin
      if (v.wait_at != 0 && !wait_done && rd_cnt >= v.wait_at) begin
        ioctl_wait = 1'b1;
        hold++;
        if (hold > 50) begin
          ioctl_wait = 1'b0;
          wait_done = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    ioctl_wait = 1'b0;
    got_done = save_done;
    got_err  = save_err;
    check($sformatf("v%0d_finished", tag), got_done | got_err, 1);
    check($sformatf("v%0d_err_pulse", tag), got_err, v.exp_err);
    check($sformatf("v%0d_done_pulse", tag), got_done, !v.exp_err);
    check($sformatf("v%0d_busy_at_end", tag), save_busy, 0);
    if (v.exp_err) check($sformatf("v%0d_err_latency", tag), cyc, 2);
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_pulse_count", tag), done_cnt + err_cnt, 1);
    check($sformatf("v%0d_sectors", tag), sec_cnt, v.exp_sec);
    check($sformatf("v%0d_reads", tag), rd_cnt, v.exp_err ? 0 : 32'(v.size));
    check($sformatf("v%0d_read_order", tag), rd_addr_err, 0);
    check($sformatf("v%0d_rd_during_wait", tag), rd_in_wait, 0);
    check($sformatf("v%0d_lba_seq", tag), lba_err, 0);
    check($sformatf("v%0d_idle_outputs", tag), {ioctl_upload, sd_wr}, 0);
    if (v.exp_sec > 0) begin
      check($sformatf("v%0d_wr_onehot", tag), last_wr, v.exp_wr);
      bad = 0;
      for (int i = 0; i < int'(v.exp_sec) * 512; i++) begin
        exp_b = (i < int'(v.size)) ? pat(23'(i)) : 8'h00;
        if (img[i] !== exp_b) bad++;
      end
      check($sformatf("v%0d_sector_data", tag), bad, 0);
    end
  endtask

  task automatic run_timeout();
    int unsigned cyc, t0, t1;
    bit          saw_wr;
    clear_counts();
    sd_en = 1'b0;
    saw_wr = 1'b0;
    t0 = 0;
    @(negedge clk);
    save_sel = 3'd1; save_size = 23'd16; save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
    cyc = 1;
    while (!save_err && cyc < TMO + 4000) begin
      if (cyc == 20) begin save_sel = 3'd0; save_req = 1'b1; end
      if (cyc == 21) save_req = 1'b0;
      if (!saw_wr && sd_wr != '0) begin saw_wr = 1'b1; t0 = cyc; end
      @(negedge clk);
      cyc++;
    end
    t1 = cyc;
    check("tmo_err_seen", save_err, 1);
    check("tmo_wr_seen", saw_wr, 1);
    check("tmo_latency", (t1 - t0 >= TMO) && (t1 - t0 <= TMO + 2), 1);
    check("tmo_wr_dropped", sd_wr, 0);
    check("tmo_busy_low", save_busy, 0);
    check("tmo_upload_low", ioctl_upload, 0);
    repeat (5) @(negedge clk);
    check("tmo_single_err", err_cnt, 1);
    check("tmo_no_done", done_cnt, 0);
    sd_en = 1'b1;
  endtask

  task automatic run_reset_mid_save();
    int unsigned cyc;
    vec_t v;
    clear_counts();
    @(negedge clk);
    save_sel = 3'd1; save_size = 23'd2048; save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
    cyc = 0;
    while (!(sd_busy && sd_wr == '0 && sd_lba == 32'd3) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_lba3_wait", sd_lba, 3);
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", save_busy, 0);
    check("rst_upload", ioctl_upload, 0);
    check("rst_lba", sd_lba, 0);
    check("rst_wr", sd_wr, 0);
    check("rst_rd_addr", {ioctl_rd, ioctl_addr}, 0);
    check("rst_wr_data", sd_wr_data, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_pulses", done_cnt + err_cnt, 0);
    v = '{3'd1, 23'd1024, 0, 1'b1, 0, 5'b00000};
    run_vec(20, v);
    mount(1, 32'd16384);
    v = '{3'd1, 23'd1024, 0, 1'b0, 2, 5'b00001};
    run_vec(21, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; save_req = 1'b0; save_sel = '0; save_size = '0;
    sd_img_mounted = '0; sd_img_size = '0; ioctl_wait = 1'b0; sd_en = 1'b1;
    clear_counts();

    vecs[0]  = '{3'd1, 23'd1024,  0,   1'b0, 2, 5'b00001};
    vecs[1]  = '{3'd2, 23'd700,   0,   1'b0, 2, 5'b00010};
    vecs[2]  = '{3'd1, 23'd1024,  300, 1'b0, 2, 5'b00001};
    vecs[3]  = '{3'd4, 23'd100,   0,   1'b1, 0, 5'b00000};
    vecs[4]  = '{3'd1, 23'd20000, 0,   1'b1, 0, 5'b00000};
    vecs[5]  = '{3'd0, 23'd10,    0,   1'b1, 0, 5'b00000};
    vecs[6]  = '{3'd6, 23'd10,    0,   1'b1, 0, 5'b00000};
    vecs[7]  = '{3'd2, 23'd0,     0,   1'b1, 0, 5'b00000};
    vecs[8]  = '{3'd3, 23'd512,   0,   1'b0, 1, 5'b00100};
    vecs[9]  = '{3'd5, 23'd513,   0,   1'b0, 2, 5'b10000};
    vecs[10] = '{3'd5, 23'd1,     0,   1'b0, 1, 5'b10000};
    vecs[11] = '{3'd3, 23'd513,   0,   1'b1, 0, 5'b00000};

    repeat (3) @(negedge clk);
    check("reset_flags", {save_busy, save_done, save_err, ioctl_upload, ioctl_rd}, 0);
    check("reset_lba", sd_lba, 0);
    check("reset_wr", sd_wr, 0);
    check("reset_ioctl_addr", ioctl_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;

    mount(0, 32'd16384);
    mount(1, 32'd16384);
    mount(2, 32'h0100_1000);
    mount(3, 32'd512);
    mount(4, 32'd0);
    mount(5, 32'd600);

    for (int k = 0; k < 12; k++) begin
      run_vec(k, vecs[k]);
    end

    run_timeout();
    run_reset_mid_save();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
